// File: rtl/prim_shifter_arbiter.sv
// Round-robin arbiter sharing one 32-bit shifter among NUM_REQ requesters,
// with a one-entry registered response slot tagged by requester ID.

module prim_shifter_32bit (
  input  logic [31:0] i_data,
  input  logic [31:0] i_shamt,
  input  logic [1:0]  i_mode,
  output logic [31:0] o_result
);

  always_comb begin
    o_result = '0;
    if (i_shamt[31:5] == '0) begin
      unique case (i_mode)
        2'b00:   o_result = i_data >> i_shamt[4:0];
        2'b01:   o_result = i_data << i_shamt[4:0];
        2'b10:   o_result = $signed(i_data) >>> i_shamt[4:0];
        default: o_result = '0;
      endcase
    end
  end

endmodule

module prim_shifter_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [32*NUM_REQ-1:0]  i_req_data,
  input  logic [32*NUM_REQ-1:0]  i_req_shamt,
  input  logic [2*NUM_REQ-1:0]   i_req_mode,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_rsp_valid,
  output logic [31:0]            o_rsp_data,
  output logic [ID_W-1:0]        o_rsp_id,
  input  logic                   i_rsp_ready
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [31:0]         rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]  grant;
  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [31:0]         sel_data, sel_shamt, shift_result;
  logic [1:0]          sel_mode;
  logic                can_accept, accept;

  // Wrap-around search as two passes: indices at/above the pointer first,
  // then those below it. Keeps every index a constant after unrolling.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_data    = '0;
    sel_shamt   = '0;
    sel_mode    = '0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!grant_found && i_req_valid[j] &&
            ((pass == 0) == (j >= 32'(ptr_q)))) begin
          grant_found = 1'b1;
          grant[j]    = 1'b1;
          grant_idx   = ID_W'(j);
          sel_data    = i_req_data[32*j +: 32];
          sel_shamt   = i_req_shamt[32*j +: 32];
          sel_mode    = i_req_mode[2*j +: 2];
        end
      end
    end
  end

  prim_shifter_32bit u_shifter (
    .i_data   (sel_data),
    .i_shamt  (sel_shamt),
    .i_mode   (sel_mode),
    .o_result (shift_result)
  );

  assign can_accept  = (state_q == ST_EMPTY) | i_rsp_ready;
  assign accept      = grant_found & can_accept;
  assign o_req_ready = grant & {NUM_REQ{can_accept & i_rst_n}};

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (accept) begin
      state_d    = ST_FULL;
      rsp_id_d   = grant_idx;
      rsp_data_d = shift_result;
      ptr_d      = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end else if (state_q == ST_FULL && i_rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign o_rsp_valid = (state_q == ST_FULL);
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_id    = rsp_id_q;

endmodule
